// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the fetch-side prefetch queue.
// Holds the SPARC nop encoding, the default depth and the {instr, pc} entry layout.
package if_fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_NOP_WORD = 32'h0100_0000;
    localparam logic [31:0] FQ_PC_INCR  = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t FQ_ENTRY_ZERO = '{instr: 32'h0000_0000, pc: 32'h0000_0000};

    // Word-align a redirect target; the low two bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundles the instruction-memory port, the IF/ID dequeue handshake and the redirect request.
// The master side is the fetch queue; the slave side is the surrounding pipeline.
interface if_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_instr;
    logic [31:0]   deq_pc;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] occupancy;

    modport master (
        output imem_addr,
        input  imem_data,
        input  deq_ready,
        output deq_valid,
        output deq_instr,
        output deq_pc,
        input  redirect,
        input  redirect_pc,
        output occupancy
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output deq_ready,
        input  deq_valid,
        input  deq_instr,
        input  deq_pc,
        output redirect,
        output redirect_pc,
        input  occupancy
    );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Circular buffer of fetch entries with head/tail pointers, an entry count and a flush.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wr_entry,
    output fetch_entry_t               rd_entry,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;

    // Next entry count from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop) begin
                head_r <= head_r + PW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; cleared on reset so nothing undefined ever sits in the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= FQ_ENTRY_ZERO;
            end
        end else if (push && !flush) begin
            mem_r[tail_r] <= wr_entry;
        end
    end

    assign rd_entry = mem_r[head_r];
    assign count    = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-side prefetch queue: owns the fetch PC, buffers {instr, pc} pairs and presents the
// head to IF/ID; a redirect flushes everything and restarts fetch at the aligned target.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = FQ_NOP_WORD
) (
    input  logic              Clk,
    input  logic              R,
    if_fetch_queue_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_r;
    fetch_entry_t  wr_entry_s;
    fetch_entry_t  head_entry_s;
    logic [CW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;

    // Handshake gating: redirect suppresses both push and pop on its edge.
    always_comb begin
        empty_s    = (count_s == {CW{1'b0}});
        full_s     = (count_s == CW'(DEPTH));
        pop_s      = bus.deq_ready & ~empty_s & ~bus.redirect;
        push_s     = (~full_s | pop_s) & ~bus.redirect;
        wr_entry_s = '{instr: bus.imem_data, pc: fetch_pc_r};
    end

    // Fetch PC: redirect target wins, otherwise advance by one word per push.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_r <= align_pc(bus.redirect_pc);
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + FQ_PC_INCR;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (R),
        .flush    (bus.redirect),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .rd_entry (head_entry_s),
        .count    (count_s)
    );

    // Head presentation; an empty queue shows a nop at PC 0 so stale storage never leaks out.
    always_comb begin
        bus.deq_valid = ~empty_s;
        if (empty_s) begin
            bus.deq_instr = NOP_WORD;
            bus.deq_pc    = 32'h0000_0000;
        end else begin
            bus.deq_instr = head_entry_s.instr;
            bus.deq_pc    = head_entry_s.pc;
        end
    end

    assign bus.imem_addr = fetch_pc_r;
    assign bus.occupancy = count_s;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue; the instruction memory holds 0xC0000000+N at address 4N.
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0100_0000;

    logic clk;
    logic r;
    int   checks;
    int   errors;

    if_fetch_queue_if #(.DEPTH(4)) bus ();

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0100_0000)
    ) dut (
        .Clk (clk),
        .R   (r),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    always_comb bus.imem_data = 32'hC000_0000 + (bus.imem_addr >> 2);

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hC000_0000 + (pc >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] occ);
        chk({tag, "_valid"}, {31'd0, bus.deq_valid}, 32'd1);
        chk({tag, "_pc"}, bus.deq_pc, pc);
        chk({tag, "_instr"}, bus.deq_instr, word_at(pc));
        chk({tag, "_occ"}, {29'd0, bus.occupancy}, occ);
    endtask

    task automatic chk_empty(input string tag, input logic [31:0] addr);
        chk({tag, "_valid"}, {31'd0, bus.deq_valid}, 32'd0);
        chk({tag, "_instr"}, bus.deq_instr, NOP);
        chk({tag, "_pc"}, bus.deq_pc, 32'd0);
        chk({tag, "_occ"}, {29'd0, bus.occupancy}, 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks          = 0;
        errors          = 0;
        r               = 1'b0;
        bus.deq_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;

        // 1. reset state before any edge
        #3;
        chk_empty("reset", 32'd0);
        tick();
        chk_empty("reset_edge", 32'd0);

        // 1/2. release with deq_ready=1, stream one instruction per cycle
        @(negedge clk);
        r             = 1'b1;
        bus.deq_ready = 1'b1;
        tick();
        chk_head("first", 32'd0, 32'd1);
        chk("first_addr", bus.imem_addr, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_head("stream", 32'(4 * i), 32'd1);
        end

        // 3. stall from reset release, fill to DEPTH, then push/pop together
        r             = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        chk_empty("rst2", 32'd0);
        @(negedge clk);
        r = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_head("fill", 32'd0, 32'(k));
        end
        chk("full_addr", bus.imem_addr, 32'd16);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_head("hold", 32'd0, 32'd4);
            chk("hold_addr", bus.imem_addr, 32'd16);
        end
        bus.deq_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_head("drain", 32'(4 * k), 32'd4);
            chk("drain_addr", bus.imem_addr, 32'(16 + 4 * k));
        end

        // 4. redirect with three entries queued
        r             = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        @(negedge clk);
        r = 1'b1;
        tick();
        tick();
        tick();
        chk_head("pre_redir", 32'd0, 32'd3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        bus.deq_ready   = 1'b1;
        tick();
        bus.redirect = 1'b0;
        chk_empty("redir", 32'h0000_0040);
        tick();
        chk_head("redir_first", 32'h0000_0040, 32'd1);
        chk("redir_addr", bus.imem_addr, 32'h0000_0044);

        // 5. misaligned redirect while full with deq_ready=1
        bus.deq_ready = 1'b0;
        tick();
        tick();
        tick();
        chk_head("full2", 32'h0000_0040, 32'd4);
        chk("full2_addr", bus.imem_addr, 32'h0000_0050);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0043;
        bus.deq_ready   = 1'b1;
        tick();
        bus.redirect = 1'b0;
        chk_empty("misalign", 32'h0000_0040);
        tick();
        chk_head("misalign_first", 32'h0000_0040, 32'd1);

        // 6. asynchronous reset between edges with three entries queued
        bus.deq_ready = 1'b0;
        tick();
        tick();
        chk_head("pre_async", 32'h0000_0040, 32'd3);
        #2;
        r = 1'b0;
        #1;
        chk_empty("async", 32'd0);
        @(negedge clk);
        r = 1'b1;
        tick();
        chk_head("after_async", 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
